fir_alu_sched: RTL and testbench
================================

FIR_ALU_SCHED -- requirements
Module: fir_alu_sched

Interface
REQ-001: Parameter NTAPS, default 8, number of FIR taps (2..64).
REQ-002: Parameter ALU_LAT, default 2, cycles from operands driven by an edge to the edge at which alu_result is sampled (>=1).
REQ-003: clk  input  1  single clock, all state updates on rising edge.
REQ-004: rst  input  1  reset, asynchronous, active-low.
REQ-005: in_valid  input  1  new input sample offered.
REQ-006: in_data  input  16  input sample.
REQ-007: in_ready  output  1  block accepts a sample this cycle.
REQ-008: out_valid  output  1  out_data holds a completed FIR output.
REQ-009: out_data  output  32  FIR output, sum of tap products modulo 2^32.
REQ-010: out_ready  input  1  consumer accepts out_data.
REQ-011: cfg_we  input  1  coefficient write strobe.
REQ-012: cfg_addr  input  clog2(NTAPS)  coefficient index.
REQ-013: cfg_data  input  16  coefficient value.
REQ-014: alu_a  output  16  ALU operand a (delay-line sample), registered.
REQ-015: alu_b  output  16  ALU operand b (coefficient), registered.
REQ-016: alu_op_sel  output  2  ALU operation; 2'b01 (multiply) while issuing, 2'b00 otherwise.
REQ-017: alu_result  input  32  ALU result.

Function
REQ-018: Storage SHALL be coef[0..NTAPS-1] and delay line x[0..NTAPS-1] (x[0] newest), 16 bits each.
REQ-019: FSM states SHALL be IDLE, ISSUE, DRAIN, DONE; in_ready = 1 only in IDLE.
REQ-020: IDLE, in_valid=1 at edge E0: x shifts (x[k] <= x[k-1], x[0] <= in_data), accumulator clears to 0, tap counter clears to 0, state -> ISSUE.
REQ-021: ISSUE: at edges E1..E_NTAPS, alu_a/alu_b load x[k]/coef[k] for k = 0..NTAPS-1, alu_op_sel = 2'b01; after edge E_NTAPS state -> DRAIN.
REQ-022: A valid-tag shift register of depth ALU_LAT SHALL track issued taps; alu_result for tap k SHALL be added to the accumulator at edge E(k+1+ALU_LAT).
REQ-023: Accumulation SHALL be a 32-bit add, wrapping modulo 2^32, no saturation; product signedness is defined by the ALU, not by this block.
REQ-024: At edge E(NTAPS+ALU_LAT), out_data SHALL load the final sum and out_valid SHALL go 1 (state -> DONE); latency from sample acceptance to out_valid is NTAPS+ALU_LAT cycles.
REQ-025: DONE: out_valid and out_data held stable until out_valid&out_ready at an edge; at that edge out_valid -> 0, state -> IDLE.
REQ-026: in_ready SHALL not be 1 in the same cycle as out_valid; no new sample is accepted before handshake completion.
REQ-027: cfg_we SHALL write coef[cfg_addr] <= cfg_data only in IDLE; cfg_we in ISSUE/DRAIN/DONE is ignored with no state change.
REQ-028: cfg_we and in_valid at the same IDLE edge: both take effect; the new coefficient is used for that sample's computation.
REQ-029: cfg_addr >= NTAPS SHALL be ignored.
REQ-030: Outside ISSUE, alu_a/alu_b SHALL hold 0 and alu_op_sel SHALL be 2'b00.

Reset
REQ-031: rst=0 SHALL immediately force state IDLE, out_valid 0, out_data 0, accumulator 0, valid tags 0, alu_a/alu_b 0, alu_op_sel 2'b00, all x[k] 0, all coef[k] 0.
REQ-032: Reset asserted mid-ISSUE/DRAIN/DONE SHALL abandon the computation; no out_valid pulse follows reset release.
REQ-033: in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification (behavioural ALU model: unsigned multiply, ALU_LAT=2, NTAPS=8)
REQ-034: Impulse: coef[k]=k+1, inputs 1,0,0,... -> out_data sequence 1,2,3,4,5,6,7,8,0.
REQ-035: Latency: sample accepted at E0 -> out_valid rises after E10; in_ready 0 from after E0 until out handshake; alu_op_sel = 2'b01 exactly 8 cycles.
REQ-036: Backpressure: out_ready=0 for 5 cycles in DONE -> out_data stable, in_ready 0, in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-037: Config lockout: cfg_we to coef[0] during ISSUE -> coef unchanged; same write in IDLE -> takes effect on next sample.
REQ-038: Wrap: all coef=0xFFFF, eight inputs 0xFFFF -> 8th output 0xFFF00008.
REQ-039: Reset mid-ISSUE: rst=0 at E4 -> outputs/state at reset values immediately, no out_valid afterwards, impulse test then passes unchanged.

Source files
------------

// File: rtl/fir_alu_sched_if.sv
// Stream, coefficient-config and external-ALU signals of fir_alu_sched.
// The slave modport is the FIR block; master is whoever drives it.
interface fir_alu_sched_if #(
  parameter int NTAPS = 8
);
  localparam int AW = $clog2(NTAPS);

  logic          in_valid;
  logic [15:0]   in_data;
  logic          in_ready;
  logic          out_valid;
  logic [31:0]   out_data;
  logic          out_ready;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [15:0]   cfg_data;
  logic [15:0]   alu_a;
  logic [15:0]   alu_b;
  logic [1:0]    alu_op_sel;
  logic [31:0]   alu_result;

  modport master (
    output in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data, alu_result,
    input  in_ready, out_valid, out_data, alu_a, alu_b, alu_op_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data, alu_result,
    output in_ready, out_valid, out_data, alu_a, alu_b, alu_op_sel
  );
endinterface

// File: rtl/fir_alu_sched.sv
// Sequential FIR: issues one tap product per cycle to an external pipelined
// ALU and accumulates the returned products into a 32-bit wrapping sum.
module fir_alu_sched #(
  parameter int NTAPS   = 8,
  parameter int ALU_LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  fir_alu_sched_if.slave bus
);
  localparam int AW = $clog2(NTAPS);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [15:0]        x_q    [NTAPS];
  logic [15:0]        x_d    [NTAPS];
  logic [15:0]        coef_q [NTAPS];
  logic [15:0]        coef_d [NTAPS];
  logic [AW-1:0]      tap_q, tap_d;
  logic [31:0]        acc_q, acc_d;
  logic [ALU_LAT-1:0] vld_q, vld_d;
  logic [ALU_LAT-1:0] last_q, last_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_data_q, out_data_d;
  logic [15:0]        alu_a_q, alu_a_d;
  logic [15:0]        alu_b_q, alu_b_d;
  logic [1:0]         op_q, op_d;
  logic               in_ready_q, in_ready_d;
  logic [31:0]        acc_sum;
  logic               issue;
  logic               issue_last;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    coef_d      = coef_q;
    tap_d       = tap_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    alu_a_d     = '0;
    alu_b_d     = '0;
    op_d        = 2'b00;
    issue       = 1'b0;
    issue_last  = 1'b0;
    acc_sum     = acc_q + bus.alu_result;

    // The oldest tag marks the cycle in which a tap's product is on alu_result.
    if (vld_q[ALU_LAT-1]) acc_d = acc_sum;

    case (state_q)
      IDLE: begin
        if (bus.cfg_we && (int'(bus.cfg_addr) < NTAPS)) coef_d[bus.cfg_addr] = bus.cfg_data;
        if (bus.in_valid) begin
          for (int unsigned k = 1; k < NTAPS; k++) x_d[k] = x_q[k-1];
          x_d[0]  = bus.in_data;
          acc_d   = '0;
          tap_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        alu_a_d = x_q[tap_q];
        alu_b_d = coef_q[tap_q];
        op_d    = 2'b01;
        issue   = 1'b1;
        if (tap_q == AW'(NTAPS - 1)) begin
          issue_last = 1'b1;
          state_d    = DRAIN;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end
      DRAIN: begin
        // Final product arrives with the last tag; publish sum including it.
        if (last_q[ALU_LAT-1]) begin
          out_data_d  = acc_sum;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    vld_d[0]  = issue;
    last_d[0] = issue_last;
    for (int unsigned i = 1; i < ALU_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      last_d[i] = last_q[i-1];
    end

    // Registered from next state so in_ready is exactly "state is IDLE".
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      x_q         <= '{default: '0};
      coef_q      <= '{default: '0};
      tap_q       <= '0;
      acc_q       <= '0;
      vld_q       <= '0;
      last_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      op_q        <= 2'b00;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      coef_q      <= coef_d;
      tap_q       <= tap_d;
      acc_q       <= acc_d;
      vld_q       <= vld_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      op_q        <= op_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op_sel = op_q;
endmodule

// File: tb/tb_fir_alu_sched.sv
// Scoreboard bench for fir_alu_sched with an unsigned-multiply ALU of latency 2.
module tb_fir_alu_sched;
  localparam int NTAPS   = 8;
  localparam int ALU_LAT = 2;
  localparam int AW      = $clog2(NTAPS);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fir_alu_sched_if #(.NTAPS(NTAPS)) bus ();
  fir_alu_sched #(.NTAPS(NTAPS), .ALU_LAT(ALU_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  // One register stage: operands driven at edge E are seen by the DUT at E+2.
  always @(posedge clk) bus.alu_result <= 32'(bus.alu_a) * 32'(bus.alu_b);

  int tests_run = 0;
  int tests_failed = 0;
  logic [15:0] tb_x    [NTAPS];
  logic [15:0] tb_coef [NTAPS];
  logic [31:0] exp_q [$];

  function automatic logic [31:0] model_sum();
    logic [31:0] s = '0;
    for (int k = 0; k < NTAPS; k++) s += 32'(tb_x[k]) * 32'(tb_coef[k]);
    return s;
  endfunction

  function automatic logic [31:0] pop_exp(input bit acc);
    if (acc && exp_q.size() > 0) return exp_q.pop_front();
    return 32'hFFFF_FFFF;
  endfunction

  task automatic cfg_write(input logic [AW-1:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_data = d;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
  endtask

  task automatic start_sample(input logic [15:0] d, input bit cfg_en, input logic [AW-1:0] ca,
                              input logic [15:0] cd, output bit acc);
    int n = 0;
    acc = 1'b0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.in_ready) return;
    bus.in_valid = 1'b1; bus.in_data = d;
    if (cfg_en) begin
      bus.cfg_we = 1'b1; bus.cfg_addr = ca; bus.cfg_data = cd;
      tb_coef[ca] = cd;
    end
    for (int k = NTAPS - 1; k > 0; k--) tb_x[k] = tb_x[k-1];
    tb_x[0] = d;
    exp_q.push_back(model_sum());
    acc = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.cfg_we = 1'b0;
  endtask

  task automatic finish_sample(input int stall, output logic [31:0] got, output int lat,
                               output int opcnt, output bit rdy_busy, output bit stable,
                               output bit after_ok, output bit tmo);
    got = '0; lat = 0; opcnt = 0; rdy_busy = 1'b0; stable = 1'b1; after_ok = 1'b0; tmo = 1'b1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (bus.alu_op_sel == 2'b01) opcnt++;
      if (bus.in_ready) rdy_busy = 1'b1;
      if (bus.out_valid) begin lat = cyc - 1; tmo = 1'b0; break; end
    end
    if (tmo) return;
    got = bus.out_data;
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 16'hBEEF;
      @(negedge clk);
      if (bus.out_data !== got || bus.out_valid !== 1'b1) stable = 1'b0;
      if (bus.in_ready) rdy_busy = 1'b1;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    after_ok = (bus.out_valid === 1'b0 && bus.in_ready === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %0d want 0", bus.out_valid); end
    tests_run++;
    if (bus.out_data !== 32'h0) begin tests_failed++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    tests_run++;
    if (bus.alu_a !== 16'h0 || bus.alu_b !== 16'h0) begin
      tests_failed++; $display("FAIL reset_alu_ops: got a=%h b=%h want 0", bus.alu_a, bus.alu_b);
    end
    tests_run++;
    if (bus.alu_op_sel !== 2'b00) begin tests_failed++; $display("FAIL reset_op_sel: got %b want 00", bus.alu_op_sel); end
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %0d want 1", bus.in_ready); end
  endtask

  task automatic test_impulse();
    logic [31:0] got, exp, want; int lat, opc; bit rb, st, aok, tmo, acc;
    for (int k = 0; k < NTAPS; k++) begin
      cfg_write(AW'(k), 16'(k + 1));
      tb_coef[k] = 16'(k + 1);
    end
    for (int i = 0; i <= NTAPS; i++) begin
      start_sample((i == 0) ? 16'd1 : 16'd0, 1'b0, '0, '0, acc);
      finish_sample(0, got, lat, opc, rb, st, aok, tmo);
      exp  = pop_exp(acc);
      want = (i < NTAPS) ? 32'(i + 1) : 32'd0;
      tests_run++;
      if (tmo || got !== exp) begin
        tests_failed++; $display("FAIL impulse_sb_%0d: got %h want %h tmo=%0d", i, got, exp, tmo);
      end
      tests_run++;
      if (got !== want) begin tests_failed++; $display("FAIL impulse_seq_%0d: got %h want %h", i, got, want); end
    end
  endtask

  task automatic test_latency();
    logic [31:0] got, exp; int lat, opc; bit rb, st, aok, tmo, acc;
    start_sample(16'h0123, 1'b0, '0, '0, acc);
    finish_sample(0, got, lat, opc, rb, st, aok, tmo);
    exp = pop_exp(acc);
    tests_run++;
    if (tmo || lat != NTAPS + ALU_LAT) begin
      tests_failed++; $display("FAIL latency: got %0d want %0d tmo=%0d", lat, NTAPS + ALU_LAT, tmo);
    end
    tests_run++;
    if (opc != NTAPS) begin tests_failed++; $display("FAIL op_sel_cycles: got %0d want %0d", opc, NTAPS); end
    tests_run++;
    if (rb) begin tests_failed++; $display("FAIL busy_in_ready: got 1 want 0"); end
    tests_run++;
    if (!aok) begin tests_failed++; $display("FAIL latency_idle_after: got 0 want 1"); end
    tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL latency_data: got %h want %h", got, exp); end
  endtask

  task automatic test_backpressure();
    logic [31:0] got, exp; int lat, opc; bit rb, st, aok, tmo, acc;
    start_sample(16'h0A0B, 1'b0, '0, '0, acc);
    finish_sample(5, got, lat, opc, rb, st, aok, tmo);
    exp = pop_exp(acc);
    tests_run++;
    if (tmo || !st) begin tests_failed++; $display("FAIL bp_stable: got 0 want 1 tmo=%0d", tmo); end
    tests_run++;
    if (rb) begin tests_failed++; $display("FAIL bp_in_ready: got 1 want 0"); end
    tests_run++;
    if (!aok) begin tests_failed++; $display("FAIL bp_release: got 0 want 1"); end
    tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL bp_data: got %h want %h", got, exp); end
    // Junk offered during the stall must not have entered the delay line.
    start_sample(16'h0002, 1'b0, '0, '0, acc);
    finish_sample(0, got, lat, opc, rb, st, aok, tmo);
    exp = pop_exp(acc);
    tests_run++;
    if (tmo || got !== exp) begin tests_failed++; $display("FAIL bp_ignored: got %h want %h", got, exp); end
  endtask

  task automatic test_cfg_lockout();
    logic [31:0] got, exp; int lat, opc; bit rb, st, aok, tmo, acc;
    cfg_write('0, 16'd3);
    tb_coef[0] = 16'd3;
    start_sample(16'h0100, 1'b0, '0, '0, acc);
    cfg_write('0, 16'h0055);
    finish_sample(0, got, lat, opc, rb, st, aok, tmo);
    exp = pop_exp(acc);
    tests_run++;
    if (tmo || got !== exp) begin tests_failed++; $display("FAIL cfg_lock_busy: got %h want %h", got, exp); end
    start_sample(16'h0001, 1'b0, '0, '0, acc);
    finish_sample(0, got, lat, opc, rb, st, aok, tmo);
    exp = pop_exp(acc);
    tests_run++;
    if (tmo || got !== exp) begin tests_failed++; $display("FAIL cfg_lock_kept: got %h want %h", got, exp); end
    cfg_write('0, 16'h0055);
    tb_coef[0] = 16'h0055;
    start_sample(16'h0004, 1'b0, '0, '0, acc);
    finish_sample(0, got, lat, opc, rb, st, aok, tmo);
    exp = pop_exp(acc);
    tests_run++;
    if (tmo || got !== exp) begin tests_failed++; $display("FAIL cfg_idle_write: got %h want %h", got, exp); end
    start_sample(16'h0007, 1'b1, AW'(0), 16'h1234, acc);
    finish_sample(0, got, lat, opc, rb, st, aok, tmo);
    exp = pop_exp(acc);
    tests_run++;
    if (tmo || got !== exp) begin tests_failed++; $display("FAIL cfg_same_edge: got %h want %h", got, exp); end
  endtask

  task automatic test_wrap();
    logic [31:0] got, exp; int lat, opc; bit rb, st, aok, tmo, acc;
    for (int k = 0; k < NTAPS; k++) begin cfg_write(AW'(k), 16'hFFFF); tb_coef[k] = 16'hFFFF; end
    for (int i = 0; i < NTAPS; i++) begin
      start_sample(16'hFFFF, 1'b0, '0, '0, acc);
      finish_sample(0, got, lat, opc, rb, st, aok, tmo);
      exp = pop_exp(acc);
      tests_run++;
      if (tmo || got !== exp) begin tests_failed++; $display("FAIL wrap_sb_%0d: got %h want %h", i, got, exp); end
    end
    tests_run++;
    if (got !== 32'hFFF0_0008) begin tests_failed++; $display("FAIL wrap_final: got %h want fff00008", got); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got, exp; int lat, opc; bit rb, st, aok, tmo, acc;
    for (int k = 0; k < NTAPS; k++) begin
      tb_coef[k] = 16'($urandom);
      cfg_write(AW'(k), tb_coef[k]);
    end
    for (int i = 0; i < 6; i++) begin
      start_sample(16'($urandom), 1'b0, '0, '0, acc);
      finish_sample(0, got, lat, opc, rb, st, aok, tmo);
      exp = pop_exp(acc);
      tests_run++;
      if (tmo || got !== exp || !aok) begin
        tests_failed++; $display("FAIL b2b_%0d: got %h want %h idle_after=%0d", i, got, exp, aok);
      end
    end
  endtask

  task automatic test_reset_mid_issue();
    bit acc, seen;
    start_sample(16'h0007, 1'b0, '0, '0, acc);
    repeat (3) @(posedge clk);
    #7;
    rst = 1'b0;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.alu_op_sel !== 2'b00 || bus.alu_a !== 16'h0 || bus.alu_b !== 16'h0) begin
      tests_failed++;
      $display("FAIL midrst_outputs: got v=%0d op=%b a=%h b=%h want all 0", bus.out_valid, bus.alu_op_sel, bus.alu_a, bus.alu_b);
    end
    tests_run++;
    if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL midrst_in_ready: got %0d want 1", bus.in_ready); end
    exp_q.delete();
    for (int k = 0; k < NTAPS; k++) begin tb_x[k] = '0; tb_coef[k] = '0; end
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin @(negedge clk); if (bus.out_valid) seen = 1'b1; end
    tests_run++;
    if (seen) begin tests_failed++; $display("FAIL midrst_no_valid: got 1 want 0"); end
    test_impulse();
  endtask

  initial begin
    for (int k = 0; k < NTAPS; k++) begin tb_x[k] = '0; tb_coef[k] = '0; end
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    test_reset();
    test_impulse();
    test_latency();
    test_backpressure();
    test_cfg_lockout();
    test_wrap();
    test_back_to_back();
    test_reset_mid_issue();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
